// File: rtl/alu_issue_sched.sv
// alu_issue_sched: round-robin issue of reservation-station ops into the shared ALU, with a result stage that broadcasts on the CDB.
module alu_issue_sched #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*32-1:0]    req_rs1,
  input  logic [N_REQ*32-1:0]    req_rs2,
  input  logic [N_REQ*32-1:0]    req_imm,
  input  logic [N_REQ*4-1:0]     req_ctrl,
  input  logic [N_REQ-1:0]       req_alusrc,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic [N_REQ-1:0]       grant,
  output logic [31:0]            alu_rs1,
  output logic [31:0]            alu_rs2,
  output logic [31:0]            alu_imm,
  output logic [3:0]             alu_ctrl,
  output logic                   alu_alusrc,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [31:0]            cdb_data,
  output logic                   cdb_zero,
  input  logic                   cdb_ready,
  output logic                   busy
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] ptr, win, idx;
  logic found, iv, rv, s1_en, s2_en, take;
  logic [TAG_W-1:0] s1_tag, sel_tag;
  logic [31:0] sel_rs1, sel_rs2, sel_imm;
  logic [3:0] sel_ctrl;
  logic sel_alusrc;
  int j;
  // First valid requester at or after ptr (with wrap) wins; its fields are muxed out.
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    j = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      idx = PW'(j);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    sel_rs1 = '0;
    sel_rs2 = '0;
    sel_imm = '0;
    sel_ctrl = '0;
    sel_alusrc = 1'b0;
    sel_tag = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PW'(i)) begin
        sel_rs1 = req_rs1[i*32 +: 32];
        sel_rs2 = req_rs2[i*32 +: 32];
        sel_imm = req_imm[i*32 +: 32];
        sel_ctrl = req_ctrl[i*4 +: 4];
        sel_alusrc = req_alusrc[i];
        sel_tag = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end
  assign s2_en = !rv || cdb_ready;
  assign s1_en = !iv || s2_en;
  assign take = rst_n && s1_en && !flush && found;
  assign grant = take ? {{(N_REQ-1){1'b0}}, 1'b1} << win : '0;
  assign cdb_valid = rv;
  assign busy = iv || rv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iv <= 1'b0;
      ptr <= '0;
      alu_rs1 <= '0;
      alu_rs2 <= '0;
      alu_imm <= '0;
      alu_ctrl <= '0;
      alu_alusrc <= 1'b0;
      s1_tag <= '0;
    end else if (flush) begin
      iv <= 1'b0;
    end else if (s1_en) begin
      iv <= take;
      if (take) begin
        ptr <= (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;
        alu_rs1 <= sel_rs1;
        alu_rs2 <= sel_rs2;
        alu_imm <= sel_imm;
        alu_ctrl <= sel_ctrl;
        alu_alusrc <= sel_alusrc;
        s1_tag <= sel_tag;
      end
    end
  end
  // Result fields only change when a real op moves in, so they stay put while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv <= 1'b0;
      cdb_data <= '0;
      cdb_zero <= 1'b0;
      cdb_tag <= '0;
    end else if (flush) begin
      rv <= 1'b0;
    end else if (s2_en) begin
      rv <= iv;
      if (iv) begin
        cdb_data <= alu_result;
        cdb_zero <= alu_zero;
        cdb_tag <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_sched.sv
// tb_alu_issue_sched: directed vector table plus hand sequences for reset, single op, zero flag and async reset.
module tb_alu_issue_sched;
  localparam int N = 4;
  localparam int TW = 6;
  logic clk = 1'b0, rst_n, flush, cdb_ready, alu_alusrc, alu_zero, cdb_valid, cdb_zero, busy;
  logic [N-1:0] req_valid, req_alusrc, grant;
  logic [N*32-1:0] req_rs1, req_rs2, req_imm;
  logic [N*4-1:0] req_ctrl;
  logic [N*TW-1:0] req_tag;
  logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_result, cdb_data, alu_b;
  logic [3:0] alu_ctrl;
  logic [TW-1:0] cdb_tag;
  logic [31:0] rs1 [N], rs2 [N], imm [N];
  logic [3:0] ctrl [N];
  logic alusrc [N];
  logic [TW-1:0] rtag [N];
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_issue_sched #(.N_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_ctrl(req_ctrl),
    .req_alusrc(req_alusrc), .req_tag(req_tag), .grant(grant),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_ctrl(alu_ctrl),
    .alu_alusrc(alu_alusrc), .alu_result(alu_result), .alu_zero(alu_zero),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_zero(cdb_zero),
    .cdb_ready(cdb_ready), .busy(busy)
  );
  always_comb begin
    req_rs1 = '0;
    req_rs2 = '0;
    req_imm = '0;
    req_ctrl = '0;
    req_alusrc = '0;
    req_tag = '0;
    for (int i = 0; i < N; i++) begin
      req_rs1[i*32 +: 32] = rs1[i];
      req_rs2[i*32 +: 32] = rs2[i];
      req_imm[i*32 +: 32] = imm[i];
      req_ctrl[i*4 +: 4] = ctrl[i];
      req_alusrc[i] = alusrc[i];
      req_tag[i*TW +: TW] = rtag[i];
    end
  end
  // Reference ALU: classic AND/OR/ADD/SUB/SLT/NOR encoding.
  always_comb begin
    alu_b = alu_alusrc ? alu_imm : alu_rs2;
    alu_result = (alu_ctrl == 4'b0000) ? (alu_rs1 & alu_b) :
                 (alu_ctrl == 4'b0001) ? (alu_rs1 | alu_b) :
                 (alu_ctrl == 4'b0010) ? (alu_rs1 + alu_b) :
                 (alu_ctrl == 4'b0110) ? (alu_rs1 - alu_b) :
                 (alu_ctrl == 4'b0111) ? {31'd0, $signed(alu_rs1) < $signed(alu_b)} :
                 (alu_ctrl == 4'b1100) ? ~(alu_rs1 | alu_b) : 32'd0;
    alu_zero = (alu_result == 32'd0);
  end
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask
  task automatic defaults();
    for (int i = 0; i < N; i++) begin
      rs1[i] = 32'(100 * (i + 1));
      rs2[i] = 32'(i + 1);
      imm[i] = '0;
      ctrl[i] = 4'b0010;
      alusrc[i] = 1'b0;
      rtag[i] = TW'(8 + i);
    end
  endtask
  typedef struct packed {
    logic [3:0] req;
    logic rdy;
    logic fl;
    logic [3:0] egnt;
    logic ecv;
    logic [5:0] etag;
  } vec_t;
  localparam int NV = 30;
  vec_t v [NV];
  function automatic vec_t mk(logic [3:0] req, logic rdy, logic fl, logic [3:0] egnt, logic ecv, logic [5:0] etag);
    mk = {req, rdy, fl, egnt, ecv, etag};
  endfunction
  initial begin
    // Starts with ptr=2 and both stages empty; requester i carries tag 8+i and result 101*(i+1).
    v[0]  = mk(4'b0011, 1, 0, 4'b0001, 0, 0);
    v[1]  = mk(4'b0011, 1, 0, 4'b0010, 0, 0);
    v[2]  = mk(4'b0000, 1, 0, 4'b0000, 1, 8);
    v[3]  = mk(4'b0000, 1, 0, 4'b0000, 1, 9);
    v[4]  = mk(4'b0000, 1, 0, 4'b0000, 0, 0);
    v[5]  = mk(4'b1111, 1, 0, 4'b0100, 0, 0);
    v[6]  = mk(4'b1111, 1, 0, 4'b1000, 0, 0);
    v[7]  = mk(4'b1111, 1, 0, 4'b0001, 1, 10);
    v[8]  = mk(4'b1111, 1, 0, 4'b0010, 1, 11);
    v[9]  = mk(4'b1111, 1, 0, 4'b0100, 1, 8);
    v[10] = mk(4'b1111, 1, 0, 4'b1000, 1, 9);
    v[11] = mk(4'b1111, 1, 0, 4'b0001, 1, 10);
    v[12] = mk(4'b1111, 1, 0, 4'b0010, 1, 11);
    v[13] = mk(4'b1111, 0, 0, 4'b0000, 1, 8);
    v[14] = mk(4'b1111, 0, 0, 4'b0000, 1, 8);
    v[15] = mk(4'b1111, 0, 0, 4'b0000, 1, 8);
    v[16] = mk(4'b0000, 1, 0, 4'b0000, 1, 8);
    v[17] = mk(4'b1111, 0, 0, 4'b0100, 1, 9);
    v[18] = mk(4'b1111, 0, 0, 4'b0000, 1, 9);
    v[19] = mk(4'b1111, 0, 0, 4'b0000, 1, 9);
    v[20] = mk(4'b0000, 1, 0, 4'b0000, 1, 9);
    v[21] = mk(4'b0000, 1, 0, 4'b0000, 1, 10);
    v[22] = mk(4'b0000, 1, 0, 4'b0000, 0, 0);
    v[23] = mk(4'b0011, 1, 0, 4'b0001, 0, 0);
    v[24] = mk(4'b0011, 1, 0, 4'b0010, 0, 0);
    v[25] = mk(4'b0011, 1, 1, 4'b0000, 1, 8);
    v[26] = mk(4'b0011, 1, 0, 4'b0001, 0, 0);
    v[27] = mk(4'b0000, 1, 0, 4'b0000, 0, 0);
    v[28] = mk(4'b0000, 1, 0, 4'b0000, 1, 8);
    v[29] = mk(4'b0000, 1, 0, 4'b0000, 0, 0);
    defaults();
    rst_n = 1'b0;
    flush = 1'b0;
    cdb_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 0, 32'(grant), 0);
    chk("rst_cdb_valid", 0, 32'(cdb_valid), 0);
    chk("rst_busy", 0, 32'(busy), 0);
    chk("rst_cdb_data", 0, cdb_data, 0);
    chk("rst_cdb_tag", 0, 32'(cdb_tag), 0);
    chk("rst_alu_rs1", 0, alu_rs1, 0);
    chk("rst_alu_ctrl", 0, 32'(alu_ctrl), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0000;
    rs1[0] = 32'd5;
    rs2[0] = 32'd3;
    rtag[0] = TW'(7);
    rs1[1] = 32'd9;
    imm[1] = 32'd9;
    alusrc[1] = 1'b1;
    ctrl[1] = 4'b0110;
    rtag[1] = TW'(21);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("single_grant", 1, 32'(grant), 32'b0001);
    chk("single_cv0", 1, 32'(cdb_valid), 0);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("single_alu_rs1", 2, alu_rs1, 5);
    chk("single_alu_rs2", 2, alu_rs2, 3);
    chk("single_alu_ctrl", 2, 32'(alu_ctrl), 32'b0010);
    chk("single_busy", 2, 32'(busy), 1);
    chk("single_cv1", 2, 32'(cdb_valid), 0);
    @(negedge clk);
    #1;
    chk("single_cdb_valid", 3, 32'(cdb_valid), 1);
    chk("single_cdb_data", 3, cdb_data, 8);
    chk("single_cdb_tag", 3, 32'(cdb_tag), 7);
    chk("single_cdb_zero", 3, 32'(cdb_zero), 0);
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("zero_grant", 4, 32'(grant), 32'b0010);
    chk("zero_cv", 4, 32'(cdb_valid), 0);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("zero_alusrc", 5, 32'(alu_alusrc), 1);
    @(negedge clk);
    #1;
    chk("zero_cdb_valid", 6, 32'(cdb_valid), 1);
    chk("zero_cdb_data", 6, cdb_data, 0);
    chk("zero_cdb_zero", 6, 32'(cdb_zero), 1);
    chk("zero_cdb_tag", 6, 32'(cdb_tag), 21);
    @(negedge clk);
    #1;
    chk("idle_busy", 7, 32'(busy), 0);
    defaults();
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      req_valid = v[k].req;
      cdb_ready = v[k].rdy;
      flush = v[k].fl;
      #1;
      chk("vec_grant", k, 32'(grant), 32'(v[k].egnt));
      chk("vec_cdb_valid", k, 32'(cdb_valid), 32'(v[k].ecv));
      if (v[k].ecv) begin
        chk("vec_cdb_tag", k, 32'(cdb_tag), 32'(v[k].etag));
        chk("vec_cdb_data", k, cdb_data, 32'(101 * (int'(v[k].etag) - 7)));
        chk("vec_cdb_zero", k, 32'(cdb_zero), 0);
      end
    end
    @(negedge clk);
    flush = 1'b0;
    cdb_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("ar_grant0", 100, 32'(grant), 32'b0010);
    @(negedge clk);
    #1;
    chk("ar_grant1", 101, 32'(grant), 32'b0100);
    @(negedge clk);
    #1;
    chk("ar_cv_pre", 102, 32'(cdb_valid), 1);
    chk("ar_busy_pre", 102, 32'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_cdb_valid", 103, 32'(cdb_valid), 0);
    chk("ar_busy", 103, 32'(busy), 0);
    chk("ar_grant", 103, 32'(grant), 0);
    chk("ar_cdb_tag", 103, 32'(cdb_tag), 0);
    chk("ar_cdb_data", 103, cdb_data, 0);
    chk("ar_alu_rs1", 103, alu_rs1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_first_grant", 104, 32'(grant), 32'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
Issue scheduler for the shared integer ALU in the out-of-order core. It arbitrates round-robin among N reservation-station requesters and latches the winner into an issue register that drives the combinational ALU. It captures the ALU result into a result register and broadcasts it on the common data bus (CDB) with its ROB tag. Backpressure from the CDB and a pipeline flush are handled without losing or duplicating operations.

Parameters:
N_REQ, 4, number of requesters (2..8)
TAG_W, 6, ROB tag width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill all in-flight ops (mispredict)
req_valid  in  N_REQ  per-requester op valid
req_rs1  in  N_REQ*32  operand A, requester i at [32i+31:32i]
req_rs2  in  N_REQ*32  operand B
req_imm  in  N_REQ*32  immediate
req_ctrl  in  N_REQ*4  ALU_ctrl code
req_alusrc  in  N_REQ  1 = use imm as operand B
req_tag  in  N_REQ*TAG_W  destination ROB tag
grant  out  N_REQ  one-hot; requester i's op is accepted at this edge
alu_rs1  out  32  to ALU rs1
alu_rs2  out  32  to ALU rs2
alu_imm  out  32  to ALU imm
alu_ctrl  out  4  to ALU ALU_ctrl
alu_alusrc  out  1  to ALU ALUSrc
alu_result  in  32  from ALU alu_out
alu_zero  in  1  from ALU flag_zero
cdb_valid  out  1  result broadcast valid
cdb_tag  out  TAG_W  result tag
cdb_data  out  32  result value
cdb_zero  out  1  captured zero flag
cdb_ready  in  1  CDB accepts this cycle
busy  out  1  iv | rv

Behaviour:
- Two stages: issue register S1 (iv, op fields, tag) and result register S2 (rv, data, zero, tag).
- Enables: s2_en = !rv | cdb_ready; s1_en = !iv | s2_en.
- grant: combinational. Asserted only when s1_en & !flush & |req_valid. Exactly one bit set. A requester must treat grant as consumption at the next edge.
- Round-robin: pointer ptr (log2 N_REQ bits), reset 0. Search starts at ptr and ascends with wrap. Winner k sets ptr <= (k+1) mod N_REQ. ptr is unchanged when nothing is granted.
- S1 load: on s1_en, iv <= |grant and the winner's fields are latched. If s1_en and nothing is granted, iv <= 0.
- alu_* outputs come directly from the S1 fields. They hold their last value when iv=0 (don't-care). They are all zero after reset.
- S2 load: on s2_en, rv <= iv, cdb_data <= alu_result, cdb_zero <= alu_zero, cdb_tag <= S1 tag.
- cdb_valid = rv. A transfer completes when rv & cdb_ready. Data and tag stay stable while cdb_valid & !cdb_ready.
- Latency: grant at edge E, result on CDB in the cycle after edge E+1 (2 cycles). Sustained throughput is 1 op/cycle while cdb_ready=1.
- Stall: rv & !cdb_ready with iv=1 gives no grant, and S1 and S2 both hold. With iv=0 one further grant is allowed to fill S1.
- Simultaneous events: an S2 drain and an S1->S2 move and a new grant may all occur in the same edge.
- flush: synchronous. At the edge iv <= 0 and rv <= 0. grant=0 during the flush cycle. ptr is held. A result presented with cdb_valid in the flush cycle is dropped regardless of cdb_ready.
- ALU_ctrl codes are passed through unchecked. The scheduler is opcode-agnostic.
- Reset (async, rst_n=0): iv=rv=0, ptr=0, all registered fields 0. Outputs: grant=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_zero=0, busy=0, alu_*=0. Reset mid-operation discards in-flight ops.

Test Plan:
- Single op: req_valid=0001 with rs1=5, rs2=3, ctrl=0010, alusrc=0, tag=7. Expect grant=0001 that cycle, alu_rs1=5 next cycle, then cdb_valid=1, data=8, tag=7, zero=0 one cycle later. Bench connects the team's ALU to the alu_* ports.
- Fairness/wrap: req_valid=1111 held for 8 cycles with cdb_ready=1. Expect grants 0001,0010,0100,1000,0001,... Tags emerge in the same order, one per cycle.
- Pointer skip: ptr=2 with req_valid=0011. Expect grant=0001 and ptr becomes 1. Next cycle with 0011 expect grant=0010.
- Backpressure: stream ops, then cdb_ready=0 for 3 cycles. Expect cdb_data/tag stable, S1 filled exactly once, no grant, and no loss or duplication after release.
- Flush: flush with iv=1 and rv=1 (tags 3 and 4). Expect grant=0, cdb_valid=0 next cycle, tags 3/4 never appear, ptr unchanged.
- Async reset mid-stream: rst_n=0 between edges. Expect cdb_valid, busy and grant to drop immediately. After release, the first grant goes to requester 0.
